// File: rtl/dma_req_chunker_if.sv
// DMA request channel: start address, byte length, completion flag and opaque control tag
// moved with a valid/ready handshake.
interface dma_req_chunker_if #(
    parameter int ADDR_BITS = 48,
    parameter int LEN_BITS  = 28,
    parameter int CTL_BITS  = 16
);
    logic                 valid;
    logic                 ready;
    logic [ADDR_BITS-1:0] paddr;
    logic [LEN_BITS-1:0]  len;
    logic                 last;
    logic [CTL_BITS-1:0]  ctl;

    modport master (output valid, paddr, len, last, ctl, input ready);
    modport slave  (input valid, paddr, len, last, ctl, output ready);
endinterface

// File: rtl/dma_req_chunker.sv
// Splits DMA requests into chunks that never cross an aligned 2^CHUNK_BITS-byte boundary.
// Order and control fields are kept; only the final chunk carries the request's last flag.
module dma_req_chunker #(
    parameter int ADDR_BITS  = 48,
    parameter int LEN_BITS   = 28,
    parameter int CHUNK_BITS = 12,
    parameter int CTL_BITS   = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    dma_req_chunker_if.slave     s_req,
    dma_req_chunker_if.master    m_req,
    output logic                 busy
);
    localparam logic [CHUNK_BITS:0] CHUNK_SIZE = {1'b1, {CHUNK_BITS{1'b0}}};

    typedef enum logic [0:0] {IDLE, SPLIT} state_t;

    state_t               state_reg, state_next;
    logic [ADDR_BITS-1:0] addr_reg, addr_next;        // start of the chunk on m_req
    logic [LEN_BITS-1:0]  rem_reg, rem_next;          // bytes left, including the presented chunk
    logic                 req_last_reg, req_last_next;
    logic [CTL_BITS-1:0]  ctl_reg, ctl_next;
    logic                 valid_reg, valid_next;
    logic [LEN_BITS-1:0]  len_reg, len_next;
    logic                 last_reg, last_next;

    logic [ADDR_BITS-1:0] calc_addr;
    logic [LEN_BITS-1:0]  calc_rem;
    logic [CHUNK_BITS:0]  room_w;
    logic [LEN_BITS-1:0]  calc_room;
    logic [LEN_BITS-1:0]  calc_len;

    // One chunk calculator serves both the first chunk (from the input) and every following one.
    always_comb begin
        calc_addr = addr_reg + ADDR_BITS'(len_reg);
        calc_rem  = rem_reg - len_reg;
        if (state_reg == IDLE) begin
            calc_addr = s_req.paddr;
            calc_rem  = s_req.len;
        end
        room_w    = CHUNK_SIZE - {1'b0, calc_addr[CHUNK_BITS-1:0]};
        calc_room = '0;
        calc_room[CHUNK_BITS:0] = room_w;
        calc_len  = (calc_rem < calc_room) ? calc_rem : calc_room;
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        rem_next      = rem_reg;
        req_last_next = req_last_reg;
        ctl_next      = ctl_reg;
        valid_next    = valid_reg;
        len_next      = len_reg;
        last_next     = last_reg;
        case (state_reg)
            IDLE: begin
                if (s_req.valid) begin
                    state_next    = SPLIT;
                    addr_next     = calc_addr;
                    rem_next      = calc_rem;
                    req_last_next = s_req.last;
                    ctl_next      = s_req.ctl;
                    valid_next    = 1'b1;
                    len_next      = calc_len;
                    last_next     = s_req.last && (calc_rem == calc_len);
                end
            end
            SPLIT: begin
                if (m_req.ready) begin
                    if (rem_reg == len_reg) begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                    end else begin
                        addr_next = calc_addr;
                        rem_next  = calc_rem;
                        len_next  = calc_len;
                        last_next = req_last_reg && (calc_rem == calc_len);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            rem_reg      <= '0;
            req_last_reg <= 1'b0;
            ctl_reg      <= '0;
            valid_reg    <= 1'b0;
            len_reg      <= '0;
            last_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            rem_reg      <= rem_next;
            req_last_reg <= req_last_next;
            ctl_reg      <= ctl_next;
            valid_reg    <= valid_next;
            len_reg      <= len_next;
            last_reg     <= last_next;
        end
    end

    // Ready is held low for as long as reset is asserted, even though the state is already IDLE.
    assign s_req.ready = aresetn && (state_reg == IDLE);
    assign m_req.valid = valid_reg;
    assign m_req.paddr = addr_reg;
    assign m_req.len   = len_reg;
    assign m_req.last  = last_reg;
    assign m_req.ctl   = ctl_reg;
    assign busy        = (state_reg == SPLIT);
endmodule

// File: tb/tb_dma_req_chunker.sv
// Directed and randomised checks of dma_req_chunker: boundary splitting, backpressure hold,
// zero length, address wrap, asynchronous reset mid-request and a 1000-request scoreboard.
`timescale 1ns/1ps
module tb_dma_req_chunker;
    localparam int AB  = 48;
    localparam int LB  = 28;
    localparam int CB  = 12;
    localparam int CTB = 16;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic busy;
    always #5 aclk = ~aclk;

    dma_req_chunker_if #(.ADDR_BITS(AB), .LEN_BITS(LB), .CTL_BITS(CTB)) s_if ();
    dma_req_chunker_if #(.ADDR_BITS(AB), .LEN_BITS(LB), .CTL_BITS(CTB)) m_if ();

    dma_req_chunker #(.ADDR_BITS(AB), .LEN_BITS(LB), .CHUNK_BITS(CB), .CTL_BITS(CTB)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_req   (s_if),
        .m_req   (m_if),
        .busy    (busy)
    );

    typedef struct {
        logic [AB-1:0]  paddr;
        logic [LB-1:0]  len;
        logic           last;
        logic [CTB-1:0] ctl;
        int             cyc;
    } chunk_t;

    chunk_t q[$];
    chunk_t rq[$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   verbose = 1'b1;
    bit   rnd_mode = 1'b0;
    logic ready_ctl = 1'b0;
    logic rnd_bit = 1'b0;

    assign m_if.ready = rnd_mode ? rnd_bit : ready_ctl;

    always @(posedge aclk) begin
        cyc     <= cyc + 1;
        rnd_bit <= 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: records each chunk handshake and checks that stalled chunks hold still.
    logic           prev_stall = 1'b0;
    logic [AB-1:0]  prev_paddr = '0;
    logic [LB-1:0]  prev_len = '0;
    logic           prev_last = 1'b0;
    logic [CTB-1:0] prev_ctl = '0;
    always @(negedge aclk) begin
        if (aresetn && prev_stall) begin
            chk("hold_valid", 64'(m_if.valid), 64'd1);
            chk("hold_paddr", 64'(m_if.paddr), 64'(prev_paddr));
            chk("hold_len",   64'(m_if.len),   64'(prev_len));
            chk("hold_last",  64'(m_if.last),  64'(prev_last));
            chk("hold_ctl",   64'(m_if.ctl),   64'(prev_ctl));
        end
        if (aresetn && m_if.valid && m_if.ready) begin
            q.push_back('{m_if.paddr, m_if.len, m_if.last, m_if.ctl, cyc});
            if (verbose)
                $display("chunk: paddr=0x%0h len=0x%0h last=%0d ctl=0x%0h cyc=%0d",
                         m_if.paddr, m_if.len, m_if.last, m_if.ctl, cyc);
        end
        prev_stall <= aresetn && m_if.valid && !m_if.ready;
        prev_paddr <= m_if.paddr;
        prev_len   <= m_if.len;
        prev_last  <= m_if.last;
        prev_ctl   <= m_if.ctl;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_req(input logic [AB-1:0] pa, input logic [LB-1:0] ln,
                            input logic lst, input logic [CTB-1:0] ct);
        int   n;
        logic hs;
        n = 0;
        s_if.valid = 1'b1;
        s_if.paddr = pa;
        s_if.len   = ln;
        s_if.last  = lst;
        s_if.ctl   = ct;
        while (1) begin
            hs = s_if.ready;
            tick();
            if (hs) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        s_if.valid = 1'b0;
    endtask

    task automatic wait_chunks(input int n, input string tag);
        int k;
        k = 0;
        while (q.size() < n) begin
            tick();
            k++;
            if (k > 200) begin
                chk(tag, 64'(q.size()), 64'(n));
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy || m_if.valid) begin
            tick();
            k++;
            if (k > 2000) begin
                chk(tag, 64'(busy), 64'd0);
                break;
            end
        end
    endtask

    task automatic exp_chunk(input int idx, input logic [AB-1:0] pa, input logic [LB-1:0] ln,
                             input logic lst, input logic [CTB-1:0] ct, input string tag);
        if (idx >= q.size()) begin
            chk({tag, "_missing"}, 64'(q.size()), 64'(idx + 1));
        end else begin
            chk({tag, "_paddr"}, 64'(q[idx].paddr), 64'(pa));
            chk({tag, "_len"},   64'(q[idx].len),   64'(ln));
            chk({tag, "_last"},  64'(q[idx].last),  64'(lst));
            chk({tag, "_ctl"},   64'(q[idx].ctl),   64'(ct));
        end
    endtask

    logic [AB-1:0]  r_pa, a;
    logic [LB-1:0]  r_ln, rem, room, exp_len, sum;
    logic           r_lst;
    logic [CTB-1:0] r_ct;
    bit             done, lost;
    int             ci;

    initial begin
        s_if.valid = 1'b0;
        s_if.paddr = '0;
        s_if.len   = '0;
        s_if.last  = 1'b0;
        s_if.ctl   = '0;

        // Reset state
        #2;
        chk("rst_sready", 64'(s_if.ready), 64'd0);
        chk("rst_valid",  64'(m_if.valid), 64'd0);
        chk("rst_busy",   64'(busy),       64'd0);
        chk("rst_paddr",  64'(m_if.paddr), 64'd0);
        chk("rst_len",    64'(m_if.len),   64'd0);
        chk("rst_last",   64'(m_if.last),  64'd0);
        chk("rst_ctl",    64'(m_if.ctl),   64'd0);
        #20 aresetn = 1'b1;
        tick();
        chk("rel_sready", 64'(s_if.ready), 64'd1);

        // Unaligned crossing
        $display("req: paddr=0x1f00 len=0x300 last=1 ctl=0xa5");
        ready_ctl = 1'b1;
        q.delete();
        send_req(48'h1F00, 28'h300, 1'b1, 16'hA5);
        chk("ua_latency", 64'(m_if.valid), 64'd1);
        chk("ua_sready0", 64'(s_if.ready), 64'd0);
        chk("ua_busy",    64'(busy),       64'd1);
        tick();
        tick();
        chk("ua_sready1", 64'(s_if.ready), 64'd1);
        chk("ua_valid0",  64'(m_if.valid), 64'd0);
        chk("ua_count",   64'(q.size()),   64'd2);
        exp_chunk(0, 48'h1F00, 28'h100, 1'b0, 16'hA5, "ua0");
        exp_chunk(1, 48'h2000, 28'h200, 1'b1, 16'hA5, "ua1");

        // Aligned multi-chunk
        $display("req: paddr=0x10000 len=0x3000 last=1 ctl=0x5a");
        q.delete();
        send_req(48'h10000, 28'h3000, 1'b1, 16'h5A);
        wait_chunks(3, "al_timeout");
        wait_idle("al_idle");
        chk("al_count", 64'(q.size()), 64'd3);
        exp_chunk(0, 48'h10000, 28'h1000, 1'b0, 16'h5A, "al0");
        exp_chunk(1, 48'h11000, 28'h1000, 1'b0, 16'h5A, "al1");
        exp_chunk(2, 48'h12000, 28'h1000, 1'b1, 16'h5A, "al2");
        if (q.size() == 3) begin
            chk("al_consec01", 64'(q[1].cyc - q[0].cyc), 64'd1);
            chk("al_consec12", 64'(q[2].cyc - q[1].cyc), 64'd1);
        end

        // Backpressure: ready low for 5 cycles on each chunk
        $display("req: paddr=0x1f00 len=0x300 last=1 ctl=0xa5 (stalled)");
        ready_ctl = 1'b0;
        q.delete();
        send_req(48'h1F00, 28'h300, 1'b1, 16'hA5);
        for (int k = 0; k < 2; k++) begin
            repeat (5) tick();
            chk("bp_stalled", 64'(q.size()), 64'(k));
            chk("bp_valid",   64'(m_if.valid), 64'd1);
            ready_ctl = 1'b1;
            tick();
            ready_ctl = 1'b0;
        end
        wait_idle("bp_idle");
        chk("bp_count", 64'(q.size()), 64'd2);
        exp_chunk(0, 48'h1F00, 28'h100, 1'b0, 16'hA5, "bp0");
        exp_chunk(1, 48'h2000, 28'h200, 1'b1, 16'hA5, "bp1");
        ready_ctl = 1'b1;

        // Zero length, then a single chunk without last
        $display("req: paddr=0x123 len=0 last=1 ctl=0x11");
        q.delete();
        send_req(48'h123, 28'h0, 1'b1, 16'h11);
        wait_chunks(1, "z_timeout");
        wait_idle("z_idle");
        chk("z_count", 64'(q.size()), 64'd1);
        exp_chunk(0, 48'h123, 28'h0, 1'b1, 16'h11, "z0");
        $display("req: paddr=0x0 len=0x800 last=0 ctl=0x22");
        q.delete();
        send_req(48'h0, 28'h800, 1'b0, 16'h22);
        wait_chunks(1, "nl_timeout");
        wait_idle("nl_idle");
        tick();
        chk("nl_count", 64'(q.size()), 64'd1);
        exp_chunk(0, 48'h0, 28'h800, 1'b0, 16'h22, "nl0");

        // Address wrap at the top of the address space
        $display("req: paddr=0xffffffffff80 len=0x100 last=1 ctl=0x77");
        q.delete();
        send_req(48'hFFFF_FFFF_FF80, 28'h100, 1'b1, 16'h77);
        wait_chunks(2, "wr_timeout");
        wait_idle("wr_idle");
        chk("wr_count", 64'(q.size()), 64'd2);
        exp_chunk(0, 48'hFFFF_FFFF_FF80, 28'h80, 1'b0, 16'h77, "wr0");
        exp_chunk(1, 48'h0,              28'h80, 1'b1, 16'h77, "wr1");

        // Reset in the middle of a split
        $display("req: paddr=0x0 len=0x4000 last=1 ctl=0x33 (reset mid-split)");
        q.delete();
        send_req(48'h0, 28'h4000, 1'b1, 16'h33);
        wait_chunks(2, "rs_timeout");
        #1 aresetn = 1'b0;
        #1;
        chk("rs_valid",  64'(m_if.valid), 64'd0);
        chk("rs_busy",   64'(busy),       64'd0);
        chk("rs_sready", 64'(s_if.ready), 64'd0);
        #10 aresetn = 1'b1;
        tick();
        chk("rs_sready_rel", 64'(s_if.ready), 64'd1);
        chk("rs_valid_rel",  64'(m_if.valid), 64'd0);
        chk("rs_count",      64'(q.size()),   64'd2);
        exp_chunk(0, 48'h0,    28'h1000, 1'b0, 16'h33, "rs0");
        exp_chunk(1, 48'h1000, 28'h1000, 1'b0, 16'h33, "rs1");
        $display("req: paddr=0x5000 len=0x1800 last=1 ctl=0x44");
        q.delete();
        send_req(48'h5000, 28'h1800, 1'b1, 16'h44);
        wait_chunks(2, "rs2_timeout");
        wait_idle("rs2_idle");
        chk("rs2_count", 64'(q.size()), 64'd2);
        exp_chunk(0, 48'h5000, 28'h1000, 1'b0, 16'h44, "rs2_0");
        exp_chunk(1, 48'h6000, 28'h800,  1'b1, 16'h44, "rs2_1");

        // 1000 random requests with random valid gaps and random ready
        $display("req: 1000 random requests");
        verbose  = 1'b0;
        rnd_mode = 1'b1;
        q.delete();
        rq.delete();
        for (int r = 0; r < 1000; r++) begin
            r_pa  = AB'({$urandom(), $urandom()});
            r_ln  = LB'($urandom_range(0, 'h2400));
            r_lst = 1'($urandom_range(0, 1));
            r_ct  = CTB'(r);
            repeat ($urandom_range(0, 2)) tick();
            send_req(r_pa, r_ln, r_lst, r_ct);
            rq.push_back('{r_pa, r_ln, r_lst, r_ct, 0});
        end
        wait_idle("rnd_idle");
        rnd_mode = 1'b0;

        ci   = 0;
        lost = 1'b0;
        for (int r = 0; r < rq.size() && !lost; r++) begin
            a    = rq[r].paddr;
            rem  = rq[r].len;
            sum  = '0;
            done = 1'b0;
            while (!done) begin
                if (ci >= q.size()) begin
                    chk("rnd_missing", 64'(q.size()), 64'(ci + 1));
                    lost = 1'b1;
                    break;
                end
                room    = LB'('h1000) - LB'(a[CB-1:0]);
                exp_len = (rem < room) ? rem : room;
                done    = (rem == exp_len);
                chk("rnd_paddr", 64'(q[ci].paddr), 64'(a));
                chk("rnd_len",   64'(q[ci].len),   64'(exp_len));
                chk("rnd_ctl",   64'(q[ci].ctl),   64'(rq[r].ctl));
                chk("rnd_last",  64'(q[ci].last),  64'(rq[r].last && done));
                chk("rnd_cross", 64'((64'(q[ci].paddr[CB-1:0]) + 64'(q[ci].len)) <= 64'h1000), 64'd1);
                sum = sum + q[ci].len;
                a   = a + AB'(exp_len);
                rem = rem - exp_len;
                ci++;
            end
            if (!lost) chk("rnd_sum", 64'(sum), 64'(rq[r].len));
        end
        chk("rnd_extra", 64'(q.size()), 64'(ci));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_req_chunker.md
Name: dma_req_chunker

Overview:
- Splits each translated DMA request into chunks that never cross an aligned 2^CHUNK_BITS-byte boundary.
- Sits directly downstream of the per-vFPGA MMU region output (host or card DMA request channel) and upstream of the static-layer DMA engines, which require boundary-safe bursts.
- Preserves request order and control fields; only the final chunk carries the request's last/ctl completion flag.

Parameters:
- ADDR_BITS, 48, physical address width
- LEN_BITS, 28, request length width in bytes
- CHUNK_BITS, 12, log2 of chunk boundary (4 KB default); legal range 6..LEN_BITS-1
- CTL_BITS, 16, opaque control/tag field carried through unchanged

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_req_valid  in  1  input request valid
- s_req_ready  out  1  input request accepted
- s_req_paddr  in  ADDR_BITS  input start address
- s_req_len  in  LEN_BITS  input length in bytes
- s_req_last  in  1  request requires completion signalling
- s_req_ctl  in  CTL_BITS  opaque control/tag
- m_req_valid  out  1  chunk valid
- m_req_ready  in  1  downstream accepts chunk
- m_req_paddr  out  ADDR_BITS  chunk start address
- m_req_len  out  LEN_BITS  chunk length
- m_req_last  out  1  s_req_last AND final chunk
- m_req_ctl  out  CTL_BITS  copy of s_req_ctl
- busy  out  1  request in progress (state != IDLE)

Behaviour:
- Reset (aresetn low, asynchronous): state=IDLE; s_req_ready=0 while aresetn is low, 1 in the first cycle after release; m_req_valid=0; busy=0; m_req_paddr, m_req_len, m_req_ctl and m_req_last=0. Any request in flight is dropped without a partial chunk; downstream sees m_req_valid fall in the same cycle.
- FSM states: IDLE, SPLIT.
- IDLE: s_req_ready=1. On s_req_valid&&s_req_ready, latch paddr, len (rem), last, ctl, then go to SPLIT. m_req_valid rises on the next cycle. Latency from input handshake to first chunk valid = 1 cycle.
- SPLIT: room = 2^CHUNK_BITS − paddr[CHUNK_BITS-1:0]. Compute room as CHUNK_BITS+1 bits, zero-extended to LEN_BITS. chunk_len = min(rem, room).
- Outputs are registered. m_req_paddr=cur addr, m_req_len=chunk_len, m_req_last=last_lat && (rem==chunk_len), m_req_ctl=ctl_lat.
- Hold rule: while m_req_valid && !m_req_ready, all m_req_* fields stay stable.
- On m_req handshake: addr += chunk_len (ADDR_BITS, wraps modulo 2^ADDR_BITS), rem −= chunk_len. If rem==chunk_len, go to IDLE and drop m_req_valid the next cycle. Otherwise stay in SPLIT and present the next chunk in the following cycle, giving 1 chunk/cycle under continuous ready.
- s_req_ready=0 in SPLIT. There is one bubble cycle between consecutive input requests.
- Zero-length request (len=0): emitted as one chunk, len=0, same paddr, m_req_last=s_req_last. Then return to IDLE.
- Aligned full chunks: paddr aligned with len a multiple of 2^CHUNK_BITS gives len/2^CHUNK_BITS chunks of exactly 2^CHUNK_BITS each.
- Address wrap: paddr near 2^ADDR_BITS wraps silently. No error is flagged; the upstream MMU guarantees legal ranges.
- m_req_ready may toggle arbitrarily. Chunk order and content must be independent of ready timing.
- busy = (state==SPLIT).

Test Plan:
- Reset mid-split: issue paddr=0x0, len=0x4000. After the 2nd chunk handshake, pulse aresetn low asynchronously. Required: m_req_valid=0 immediately, busy=0; after release, s_req_ready=1 and a new request splits from scratch.
- Unaligned crossing: paddr=0x1F00, len=0x300, last=1, ctl=0xA5, ready=1. Required chunks: (0x1F00, 0x100, last=0, ctl=0xA5) then (0x2000, 0x200, last=1, ctl=0xA5). s_req_ready returns to 1 one cycle after the 2nd handshake.
- Aligned multi-chunk: paddr=0x10000, len=0x3000, last=1. Required: 3 chunks of 0x1000 at 0x10000, 0x11000, 0x12000 on consecutive cycles; last only on the third.
- Backpressure: same stimulus as the unaligned case with m_req_ready low for 5 cycles on each chunk. Required: fields stable while stalled; identical chunk sequence.
- Zero length and no-last: len=0, paddr=0x123, last=1 gives one chunk (0x123, 0, last=1). Then paddr=0x0, len=0x800, last=0 gives one chunk with last=0.
- Back-to-back inputs with a random valid/ready pattern, 1000 requests: the scoreboard sum of chunk lens equals the input len per request; no chunk crosses a 4 KB boundary; order and ctl are preserved.
